// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU. Decodes ALUOpcode/Function3/Function7 into a 4-bit
//   control code, runs the operation on XLEN-bit operands and presents a
//   registered result over valid/ready handshakes. Single-cycle operations
//   have one cycle of latency; MUL/MULH/MULHU use an iterative shift-add
//   multiplier (XLEN steps plus one sign-fix cycle).
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   InValid / InReady        request handshake
//   ALUOpcode, Function3,
//   Function7                instruction fields to decode
//   OperandA, OperandB       source operands (B may be an immediate)
//   OutValid / OutReady      result handshake
//   Result, Zero             registered result and Result==0 flag
//   IllegalOp                unsupported encoding (Result forced to 0)
//   ALUControl               control code of the held result (1111 = illegal)
//   Busy                     multiplier iterating
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            InValid,
  output logic            InReady,
  input  logic [1:0]      ALUOpcode,
  input  logic [2:0]      Function3,
  input  logic [6:0]      Function7,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            IllegalOp,
  output logic [3:0]      ALUControl,
  output logic            Busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_SLTU  = 4'b1000;
  localparam logic [3:0] C_SLL   = 4'b1001;
  localparam logic [3:0] C_SRL   = 4'b1010;
  localparam logic [3:0] C_SRA   = 4'b1011;
  localparam logic [3:0] C_MUL   = 4'b1100;
  localparam logic [3:0] C_MULH  = 4'b1101;
  localparam logic [3:0] C_MULHU = 4'b1110;
  localparam logic [3:0] C_ILL   = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_FIX} state_t;

  state_t state_q, state_d;

  function automatic logic [3:0] decode_op(input logic [1:0] op,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    logic [3:0] base;
    logic [3:0] code;
    case (f3)
      3'b000:  base = C_ADD;
      3'b001:  base = C_SLL;
      3'b010:  base = C_SLT;
      3'b011:  base = C_SLTU;
      3'b100:  base = C_XOR;
      3'b101:  base = C_SRL;
      3'b110:  base = C_OR;
      default: base = C_AND;
    endcase
    code = C_ILL;
    case (op)
      2'b00: code = C_ADD;
      2'b01: code = C_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          code = base;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      code = C_SUB;
          else if (f3 == 3'b101) code = C_SRA;
        end else if (f7 == 7'b0000001 && MUL_EN) begin
          if (f3 == 3'b000)      code = C_MUL;
          else if (f3 == 3'b001) code = C_MULH;
          else if (f3 == 3'b011) code = C_MULHU;
        end
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings
        if (f3 == 3'b001) begin
          if (f7 == 7'b0000000) code = C_SLL;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0000000)      code = C_SRL;
          else if (f7 == 7'b0100000) code = C_SRA;
        end else begin
          code = base;
        end
      end
    endcase
    return code;
  endfunction

  function automatic logic [XLEN-1:0] exec_op(input logic [3:0]      code,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (code)
      C_AND:   r = a & b;
      C_OR:    r = a | b;
      C_ADD:   r = a + b;
      C_XOR:   r = a ^ b;
      C_SUB:   r = a - b;
      C_SLT:   r = {{(XLEN-1){1'b0}}, (sa < sb)};
      C_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      C_SLL:   r = a << sh;
      C_SRL:   r = a >> sh;
      C_SRA:   r = sa >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [3:0]        code_in;
  logic              is_mul_in;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   ex_res;
  logic              accept;

  logic              vld_p1;
  logic [XLEN-1:0]   res_p1;
  logic              zero_p1;
  logic              ill_p1;
  logic [3:0]        ctl_p1;

  logic [2*XLEN-1:0] acc_p0;
  logic [2*XLEN-1:0] mcand_p0;
  logic [XLEN-1:0]   mplier_p0;
  logic              neg_p0;
  logic [3:0]        mctl_p0;
  logic [SHW-1:0]    cnt_p0;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign code_in   = decode_op(ALUOpcode, Function3, Function7);
  assign is_mul_in = (code_in == C_MUL) || (code_in == C_MULH) || (code_in == C_MULHU);
  // MUL low half is identical for signed/unsigned, so only MULHU skips sign handling
  assign neg_a     = (code_in != C_MULHU) && OperandA[XLEN-1];
  assign neg_b     = (code_in != C_MULHU) && OperandB[XLEN-1];
  assign mag_a     = neg_a ? (~OperandA + XLEN'(1)) : OperandA;
  assign mag_b     = neg_b ? (~OperandB + XLEN'(1)) : OperandB;
  assign ex_res    = exec_op(code_in, OperandA, OperandB);
  assign accept    = InValid && InReady;

  assign prod      = neg_p0 ? (~acc_p0 + (2*XLEN)'(1)) : acc_p0;
  assign mul_res   = (mctl_p0 == C_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    InReady = 1'b0;
    Busy    = 1'b0;
    case (state_q)
      IDLE: begin
        InReady = !vld_p1 || OutReady;
        if (InValid && (!vld_p1 || OutReady) && is_mul_in) state_d = MUL_RUN;
      end
      MUL_RUN: begin
        Busy = 1'b1;
        if (cnt_p0 == LAST_STEP) state_d = MUL_FIX;
      end
      MUL_FIX: begin
        Busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- p0: iterative multiplier, one shift-add step per MUL_RUN cycle ----
  always_ff @(posedge clk) begin
    if (accept && is_mul_in) begin
      acc_p0    <= '0;
      mcand_p0  <= {{XLEN{1'b0}}, mag_a};
      mplier_p0 <= mag_b;
      neg_p0    <= neg_a ^ neg_b;
      mctl_p0   <= code_in;
    end else if (state_q == MUL_RUN) begin
      if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // ---- p1: output registers, loaded by single-cycle accept or MUL_FIX ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b1;
      ill_p1  <= 1'b0;
      ctl_p1  <= '0;
      cnt_p0  <= '0;
    end else begin
      if (accept && !is_mul_in) begin
        vld_p1  <= 1'b1;
        res_p1  <= ex_res;
        zero_p1 <= (ex_res == '0);
        ill_p1  <= (code_in == C_ILL);
        ctl_p1  <= code_in;
      end else if (state_q == MUL_FIX) begin
        vld_p1  <= 1'b1;
        res_p1  <= mul_res;
        zero_p1 <= (mul_res == '0);
        ill_p1  <= 1'b0;
        ctl_p1  <= mctl_p0;
      end else if (OutReady) begin
        vld_p1  <= 1'b0;
      end
      if (accept)                  cnt_p0 <= '0;
      else if (state_q == MUL_RUN) cnt_p0 <= cnt_p0 + SHW'(1);
    end
  end

  assign OutValid   = vld_p1;
  assign Result     = res_p1;
  assign Zero       = zero_p1;
  assign IllegalOp  = ill_p1;
  assign ALUControl = ctl_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Bench for alu_exec_unit (XLEN=32, MUL_EN=1). A cycle-level behavioural
//   model computes results from the instruction fields with plain 64-bit
//   arithmetic and tracks handshake state; a negedge monitor compares the
//   DUT against it every cycle. Directed sequences pin literal values.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [1:0]  ALUOpcode;
  logic [2:0]  Function3;
  logic [6:0]  Function7;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Zero;
  logic        IllegalOp;
  logic [3:0]  ALUControl;
  logic        Busy;

  alu_exec_unit #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReady(InReady),
    .ALUOpcode(ALUOpcode), .Function3(Function3), .Function7(Function7),
    .OperandA(OperandA), .OperandB(OperandB),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Zero(Zero), .IllegalOp(IllegalOp),
    .ALUControl(ALUControl), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  // model state
  int          m_busy = 0;
  logic        m_vld  = 1'b0;
  logic [31:0] m_res  = '0;
  logic [3:0]  m_ctl  = '0;
  logic        m_ill  = 1'b0;
  logic [31:0] p_res  = '0;
  logic [3:0]  p_ctl  = '0;
  logic [31:0] got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] rt;
    case (f3)
      3'd0: rt = 4'h2; 3'd1: rt = 4'h9; 3'd2: rt = 4'h7; 3'd3: rt = 4'h8;
      3'd4: rt = 4'h3; 3'd5: rt = 4'hA; 3'd6: rt = 4'h1; default: rt = 4'h0;
    endcase
    if (op == 2'd0) return 4'h2;
    if (op == 2'd1) return 4'h6;
    if (op == 2'd2) begin
      if (f7 == 7'h00) return rt;
      if (f7 == 7'h20 && f3 == 3'd0) return 4'h6;
      if (f7 == 7'h20 && f3 == 3'd5) return 4'hB;
      if (f7 == 7'h01 && f3 == 3'd0) return 4'hC;
      if (f7 == 7'h01 && f3 == 3'd1) return 4'hD;
      if (f7 == 7'h01 && f3 == 3'd3) return 4'hE;
      return 4'hF;
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? 4'h9 : 4'hF;
    if (f3 == 3'd5) return (f7 == 7'h00) ? 4'hA : ((f7 == 7'h20) ? 4'hB : 4'hF);
    return rt;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (c)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return 32'(longint'(a) + longint'(b));
      4'h3: return a ^ b;
      4'h6: return 32'(longint'(a) - longint'(b));
      4'h7: return (sa < sb) ? 32'd1 : 32'd0;
      4'h8: return (a < b) ? 32'd1 : 32'd0;
      4'h9: return a << sh;
      4'hA: return a >> sh;
      4'hB: return 32'(sa >>> sh);
      4'hC: begin p = 64'(sa * sb); return p[31:0]; end
      4'hD: begin p = 64'(sa * sb); return p[63:32]; end
      4'hE: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    logic        er;
    logic        ld;
    logic [3:0]  c;
    logic [31:0] r;
    if (mon_en) begin
      er = (m_busy == 0) && (!m_vld || OutReady);
      chk("OutValid", OutValid, m_vld);
      chk("InReady", InReady, er);
      chk("Busy", Busy, m_busy != 0);
      if (m_vld) begin
        chk("Result", Result, m_res);
        chk("Zero", Zero, m_res == 32'd0);
        chk("IllegalOp", IllegalOp, m_ill);
        chk("ALUControl", ALUControl, m_ctl);
      end
      if (OutValid && OutReady) got_q.push_back(Result);
      if (rst) begin
        m_vld  = 1'b0;
        m_busy = 0;
      end else begin
        ld = 1'b0;
        if (m_busy != 0) begin
          m_busy--;
          if (m_busy == 0) begin
            ld = 1'b1; m_res = p_res; m_ctl = p_ctl; m_ill = 1'b0;
          end
        end else if (InValid && er) begin
          c = ref_ctl(ALUOpcode, Function3, Function7);
          r = ref_res(c, OperandA, OperandB);
          if (c >= 4'hC && c <= 4'hE) begin
            m_busy = XLEN + 1; p_res = r; p_ctl = c;
          end else begin
            ld = 1'b1; m_res = r; m_ctl = c; m_ill = (c == 4'hF);
          end
        end
        if (ld)            m_vld = 1'b1;
        else if (OutReady) m_vld = 1'b0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic acc;
    InValid = 1'b1; ALUOpcode = op; Function3 = f3; Function7 = f7;
    OperandA = a; OperandB = b;
    n = 0;
    do begin
      @(negedge clk); acc = InReady;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    chk("send_accept", acc, 1'b1);
    InValid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!OutValid && n < 60);
    chk(name, OutValid, 1'b1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom % 40);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] rnd_f7();
    case ($urandom % 4)
      0: return 7'h00;
      1: return 7'h20;
      2: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin : main
    logic seen;
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    ALUOpcode = '0; Function3 = '0; Function7 = '0; OperandA = '0; OperandB = '0;
    @(posedge clk); #1; mon_en = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_OutValid", OutValid, 1'b0);
    chk("rst_Result", Result, 32'd0);
    chk("rst_Zero", Zero, 1'b1);
    chk("rst_InReady", InReady, 1'b1);
    chk("rst_Busy", Busy, 1'b0);
    chk("rst_IllegalOp", IllegalOp, 1'b0);
    chk("rst_ALUControl", ALUControl, 4'b0000);

    // R-type SUB
    @(posedge clk); #1;
    send(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
    @(negedge clk);
    chk("sub_valid", OutValid, 1'b1);
    chk("sub_result", Result, 32'hFFFF_FFFE);
    chk("sub_ctl", ALUControl, 4'b0110);
    chk("sub_zero", Zero, 1'b0);

    // I-type SRA / SRL
    send(2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
    @(negedge clk);
    chk("srai_result", Result, 32'hF800_0000);
    chk("srai_ctl", ALUControl, 4'b1011);
    send(2'b11, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4);
    @(negedge clk);
    chk("srli_result", Result, 32'h0800_0000);
    chk("srli_ctl", ALUControl, 4'b1010);

    // MULH with exact latency, operands scrambled while running
    send(2'b10, 3'b001, 7'b0000001, 32'hFFFF_FFFD, 32'd7);
    OperandA = $urandom; OperandB = $urandom; Function3 = 3'($urandom);
    for (int i = 0; i < XLEN + 1; i++) begin
      @(negedge clk);
      chk("mulh_busy", Busy, 1'b1);
      chk("mulh_inready", InReady, 1'b0);
      chk("mulh_early_valid", OutValid, 1'b0);
    end
    @(negedge clk);
    chk("mulh_valid", OutValid, 1'b1);
    chk("mulh_result", Result, 32'hFFFF_FFFF);
    chk("mulh_busy_done", Busy, 1'b0);
    send(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFD, 32'd7);
    wait_valid("mul_timeout");
    chk("mul_result", Result, 32'hFFFF_FFEB);
    chk("mul_ctl", ALUControl, 4'b1100);

    // back-to-back ADDs with a 3-cycle stall
    repeat (2) @(posedge clk);
    #1; got_q.delete();
    fork
      for (int i = 0; i < 10; i++)
        send(2'b00, 3'($urandom), 7'($urandom), 32'(1000 + i), 32'(i * 3));
      begin
        repeat (4) @(posedge clk);
        #1 OutReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 OutReady = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("b2b_count", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < got_q.size()) chk("b2b_order", got_q[i], 32'(1000 + i * 4));

    // illegal encoding
    @(posedge clk); #1;
    send(2'b10, 3'b010, 7'b0000001, $urandom, $urandom);
    @(negedge clk);
    chk("ill_flag", IllegalOp, 1'b1);
    chk("ill_result", Result, 32'd0);
    chk("ill_ctl", ALUControl, 4'b1111);
    chk("ill_zero", Zero, 1'b1);

    // reset during MUL_RUN
    send(2'b10, 3'b000, 7'b0000001, 32'd12345, 32'd678);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_result", Result, 32'd0);
    chk("abort_zero", Zero, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (OutValid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 1'b0);

    // randomized traffic, model-checked every cycle
    @(posedge clk); #1;
    for (int k = 0; k < 3000; k++) begin
      InValid   = ($urandom % 4) != 0;
      ALUOpcode = 2'($urandom);
      Function3 = 3'($urandom);
      Function7 = rnd_f7();
      OperandA  = rnd_val();
      OperandB  = rnd_val();
      OutReady  = ($urandom % 4) != 0;
      rst       = ($urandom % 400) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
